// File: rtl/muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO, single-cycle MTxx |
// | Option MULDIV_FAST_MUL_EN: one-cycle combinational multiply. Rev 1.0     |
// +--------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_b;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_muldiv;
  logic                 w_signed;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_new_rem;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign hi       = r_hi;
  assign lo       = r_lo;

  assign w_accept = in_valid && in_ready && !flush;
  assign w_muldiv = ~op[2];
  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_abs_b  = (w_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Multiply: r_b holds the multiplicand, r_acc low half the multiplier bits.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);

  // Divide: r_acc = {partial remainder, dividend/quotient bits}, r_b = divisor.
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_b};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_new_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // A zero divisor leaves the dividend magnitude in the remainder, so the
  // sign-corrected remainder is the original src_a; only lo needs overriding.
  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = w_rem;
      w_fix_lo = (r_b == '0) ? '1 : w_quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_muldiv) begin
              r_is_div <= op[1];
              r_neg_q  <= w_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
              r_neg_r  <= w_signed & src_a[WIDTH-1];
              r_cnt    <= '0;
              if (op[1]) begin
                r_b     <= w_abs_b;
                r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                r_state <= S_RUN;
              end else begin
                r_b     <= w_abs_a;
`ifdef MULDIV_FAST_MUL_EN
                r_acc   <= w_fast_prod;
                r_state <= S_FIX;
`else
                r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                r_state <= S_RUN;
`endif
              end
            end else if (op == 3'b100) begin
              r_hi <= src_a;
            end else if (op == 3'b101) begin
              r_lo <= src_a;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            if (r_is_div)
              r_acc <= {w_new_rem, r_acc[WIDTH-2:0], w_ge};
            else
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(WIDTH - 1))
              r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_muldiv_unit : directed self-checking bench for muldiv_unit (WIDTH=32)  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_muldiv_unit;
  localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request for a single cycle; returns at the negedge after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Cycle index of the done pulse, counting the accept cycle as 0.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int lat;
  int pulses;
  int hi_moved;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = 3'b000;
    src_a    = '0;
    src_b    = '0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULT -3 * 5
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    check("mult_busy", busy, 1'b1);
    check("mult_ready", in_ready, 1'b0);
    wait_done(lat);
    check("mult_lat", lat, MUL_LAT);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFF1);
    check("mult_ready_done", in_ready, 1'b1);
    @(negedge clk);
    check("mult_done_pulse", done, 1'b0);

    // MULTU max * max
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat);
    check("multu_lat", lat, MUL_LAT);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    @(negedge clk);

    // DIV -7 / 2
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    hi_moved = 0;
    lat = 1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy && hi !== 32'hFFFF_FFFE) hi_moved++;
      @(negedge clk);
      lat++;
    end
    check("div_lat", lat, DIV_LAT);
    check("div_hi_stable", hi_moved, 0);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    @(negedge clk);

    // DIV 7 / -2 : quotient toward zero, remainder follows dividend
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_done(lat);
    check("div2_lo", lo, 32'hFFFF_FFFD);
    check("div2_hi", hi, 32'h0000_0001);
    @(negedge clk);

    // DIVU 7 / 0
    issue(OP_DIVU, 32'd7, 32'd0);
    wait_done(lat);
    check("divu0_lat", lat, DIV_LAT);
    check("divu0_lo", lo, 32'hFFFF_FFFF);
    check("divu0_hi", hi, 32'h0000_0007);
    @(negedge clk);

    // DIV -8 / 0 (signed divide by zero)
    issue(OP_DIV, 32'hFFFF_FFF8, 32'd0);
    wait_done(lat);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'hFFFF_FFF8);
    @(negedge clk);

    // DIV most-negative / -1
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0000_0000);
    @(negedge clk);

    // Flush mid-DIV
    issue(OP_MTHI, 32'h11, 32'h0);
    issue(OP_MTLO, 32'h22, 32'h0);
    check("mthi_hi", hi, 32'h11);
    check("mtlo_lo", lo, 32'h22);
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    check("flush_no_done", pulses, 0);
    check("flush_hi", hi, 32'h11);
    check("flush_lo", lo, 32'h22);
    issue(OP_MTLO, 32'h5, 32'h0);
    check("post_flush_lo", lo, 32'h5);
    check("post_flush_hi", hi, 32'h11);

    // Flush in IDLE blocks acceptance
    flush = 1'b1;
    issue(OP_MTHI, 32'h99, 32'h0);
    flush = 1'b0;
    check("idle_flush_hi", hi, 32'h11);

    // Back-to-back: DIVU held valid while MULTU is busy
    in_valid = 1'b1;
    op       = OP_MULTU;
    src_a    = 32'd3;
    src_b    = 32'd4;
    @(negedge clk);
    op    = OP_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    wait_done(lat);
    check("b2b_mul_lat", lat, MUL_LAT);
    check("b2b_mul_hi", hi, 32'd0);
    check("b2b_mul_lo", lo, 32'd12);
    check("b2b_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_div_busy", busy, 1'b1);
    wait_done(lat);
    check("b2b_div_lat", lat, DIV_LAT);
    check("b2b_div_hi", hi, 32'd2);
    check("b2b_div_lo", lo, 32'd14);
    @(negedge clk);

    // Asynchronous reset mid-DIV
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 32'h0);
    check("arst_lo", lo, 32'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
